// File: rtl/pcs_receive_pkg.sv
// Shared definitions for the 1000BASE-X PCS receive path: special code
// groups in both running disparities, SUDI field positions and FSM states.
package pcs_receive_pkg;

    localparam int SUDI_EVEN   = 10;
    localparam int SUDI_CG_MSB = 9;

    localparam logic [9:0] K28_5_N = 10'b0011111010;
    localparam logic [9:0] K28_5_P = 10'b1100000101;
    localparam logic [9:0] K27_7_N = 10'b1101101000;
    localparam logic [9:0] K27_7_P = 10'b0010010111;
    localparam logic [9:0] K29_7_N = 10'b1011101000;
    localparam logic [9:0] K29_7_P = 10'b0100010111;
    localparam logic [9:0] K23_7_N = 10'b1110101000;
    localparam logic [9:0] K23_7_P = 10'b0001010111;

    typedef enum logic [3:0] {
        LINK_FAILED,
        WAIT_FOR_K,
        RX_K,
        IDLE_D,
        CARRIER_ERR,
        START_OF_PACKET,
        RECEIVE,
        EOP,
        EXTEND
    } rx_state_t;

    function automatic logic cg_match(
        input logic [9:0] cg,
        input logic [9:0] rd_n,
        input logic [9:0] rd_p
    );
        return (cg == rd_n) || (cg == rd_p);
    endfunction

endpackage

// File: rtl/pcs_receive_dec_8b10b.sv
// Combinational 8b/10b decoder; accepts either running disparity form
// and flags control groups. Disparity itself is not tracked.
module dec_8b10b (
    input  logic [9:0] code_group,
    output logic [7:0] octet,
    output logic       is_k,
    output logic       valid
);

    logic [5:0] six;
    logic [3:0] four;
    logic [3:0] four_adj;
    logic [4:0] x;
    logic [2:0] y;
    logic       ok6;
    logic       ok4;
    logic       k28;
    logic       alt;
    logic       a7_ok;
    logic       k7_ok;

    assign six  = code_group[9:4];
    assign four = code_group[3:0];

    always_comb begin
        x   = 5'd0;
        ok6 = 1'b1;
        k28 = 1'b0;
        case (six)
            6'b100111, 6'b011000: x = 5'd0;
            6'b011101, 6'b100010: x = 5'd1;
            6'b101101, 6'b010010: x = 5'd2;
            6'b110001:            x = 5'd3;
            6'b110101, 6'b001010: x = 5'd4;
            6'b101001:            x = 5'd5;
            6'b011001:            x = 5'd6;
            6'b111000, 6'b000111: x = 5'd7;
            6'b111001, 6'b000110: x = 5'd8;
            6'b100101:            x = 5'd9;
            6'b010101:            x = 5'd10;
            6'b110100:            x = 5'd11;
            6'b001101:            x = 5'd12;
            6'b101100:            x = 5'd13;
            6'b011100:            x = 5'd14;
            6'b010111, 6'b101000: x = 5'd15;
            6'b011011, 6'b100100: x = 5'd16;
            6'b100011:            x = 5'd17;
            6'b010011:            x = 5'd18;
            6'b110010:            x = 5'd19;
            6'b001011:            x = 5'd20;
            6'b101010:            x = 5'd21;
            6'b011010:            x = 5'd22;
            6'b111010, 6'b000101: x = 5'd23;
            6'b110011, 6'b001100: x = 5'd24;
            6'b100110:            x = 5'd25;
            6'b010110:            x = 5'd26;
            6'b110110, 6'b001001: x = 5'd27;
            6'b001110:            x = 5'd28;
            6'b101110, 6'b010001: x = 5'd29;
            6'b011110, 6'b100001: x = 5'd30;
            6'b101011, 6'b010100: x = 5'd31;
            6'b001111, 6'b110000: begin
                x   = 5'd28;
                k28 = 1'b1;
            end
            default: ok6 = 1'b0;
        endcase
    end

    // K28 in RD+ carries the inverted 4b group
    assign four_adj = (six == 6'b110000) ? ~four : four;

    always_comb begin
        y   = 3'd0;
        ok4 = 1'b1;
        alt = 1'b0;
        case (four_adj)
            4'b1011, 4'b0100: y = 3'd0;
            4'b1001:          y = 3'd1;
            4'b0101:          y = 3'd2;
            4'b1100, 4'b0011: y = 3'd3;
            4'b1101, 4'b0010: y = 3'd4;
            4'b1010:          y = 3'd5;
            4'b0110:          y = 3'd6;
            4'b1110, 4'b0001: y = 3'd7;
            4'b0111, 4'b1000: begin
                y   = 3'd7;
                alt = 1'b1;
            end
            default: ok4 = 1'b0;
        endcase
    end

    assign a7_ok = ok6 && !k28 && (x inside {5'd11, 5'd13, 5'd14,
                                             5'd17, 5'd18, 5'd20});
    assign k7_ok = ok6 && !k28 && (x inside {5'd23, 5'd27, 5'd29, 5'd30});

    always_comb begin
        valid = 1'b0;
        is_k  = 1'b0;
        if (k28) begin
            valid = ok4 && ((y != 3'd7) || alt);
            is_k  = valid;
        end else if (alt && k7_ok) begin
            valid = 1'b1;
            is_k  = 1'b1;
        end else begin
            valid = ok6 && ok4 && (!alt || a7_ok);
        end
    end

    assign octet = {y, x};

endmodule

// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive FSM: turns synchronized code groups into
// GMII RXD/RX_DV/RX_ER with one cycle of registered latency.
module pcs_receive
    import pcs_receive_pkg::*;
#(
    parameter logic [7:0] PREAMBLE_BYTE = 8'h55,
    parameter logic [7:0] FALSE_CARRIER = 8'h0E
) (
    input  logic        Clk,
    input  logic        mr_main_reset,
    input  logic        code_sync_status,
    input  logic [10:0] SUDI,
    output logic [7:0]  RXD,
    output logic        RX_DV,
    output logic        RX_ER,
    output logic        receiving
);

    rx_state_t  state;
    rx_state_t  state_nx;
    logic [7:0] rxd_nx;
    logic       dv_nx;
    logic       er_nx;
    logic       recv_nx;

    logic [9:0] cg;
    logic       rx_even;
    logic [7:0] d_octet;
    logic       d_is_k;
    logic       d_valid;
    logic       is_d;
    logic       is_k285;
    logic       is_s;
    logic       is_t;
    logic       is_r;

    assign cg      = SUDI[SUDI_CG_MSB:0];
    assign rx_even = SUDI[SUDI_EVEN];

    dec_8b10b u_dec (
        .code_group (cg),
        .octet      (d_octet),
        .is_k       (d_is_k),
        .valid      (d_valid)
    );

    assign is_d    = d_valid && !d_is_k;
    assign is_k285 = cg_match(cg, K28_5_N, K28_5_P);
    assign is_s    = cg_match(cg, K27_7_N, K27_7_P);
    assign is_t    = cg_match(cg, K29_7_N, K29_7_P);
    assign is_r    = cg_match(cg, K23_7_N, K23_7_P);

    always_comb begin
        state_nx = state;
        rxd_nx   = 8'h00;
        dv_nx    = 1'b0;
        er_nx    = 1'b0;
        recv_nx  = 1'b0;
        if (!code_sync_status) begin
            // losing sync mid-packet is reported as a receive error
            state_nx = LINK_FAILED;
            er_nx    = receiving;
        end else begin
            unique case (state)
                LINK_FAILED: state_nx = WAIT_FOR_K;
                WAIT_FOR_K: begin
                    if (is_k285 && rx_even)
                        state_nx = RX_K;
                end
                RX_K: state_nx = is_d ? IDLE_D : WAIT_FOR_K;
                IDLE_D: begin
                    if (is_k285) begin
                        state_nx = RX_K;
                    end else if (is_s) begin
                        state_nx = START_OF_PACKET;
                        dv_nx    = 1'b1;
                        rxd_nx   = PREAMBLE_BYTE;
                        recv_nx  = 1'b1;
                    end else begin
                        state_nx = CARRIER_ERR;
                        er_nx    = 1'b1;
                        rxd_nx   = FALSE_CARRIER;
                    end
                end
                CARRIER_ERR: state_nx = is_k285 ? RX_K : WAIT_FOR_K;
                START_OF_PACKET, RECEIVE: begin
                    recv_nx  = 1'b1;
                    state_nx = RECEIVE;
                    if (is_d) begin
                        dv_nx  = 1'b1;
                        rxd_nx = d_octet;
                    end else if (is_t) begin
                        state_nx = EOP;
                    end else if (is_k285 && rx_even) begin
                        state_nx = RX_K;
                        er_nx    = 1'b1;
                        recv_nx  = 1'b0;
                    end else begin
                        dv_nx = 1'b1;
                        er_nx = 1'b1;
                    end
                end
                EOP: begin
                    if (is_r) begin
                        state_nx = EXTEND;
                    end else begin
                        state_nx = WAIT_FOR_K;
                        er_nx    = 1'b1;
                    end
                end
                EXTEND: begin
                    if (!is_r)
                        state_nx = is_k285 ? RX_K : WAIT_FOR_K;
                end
                default: state_nx = LINK_FAILED;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!mr_main_reset) begin
            state     <= LINK_FAILED;
            RXD       <= 8'h00;
            RX_DV     <= 1'b0;
            RX_ER     <= 1'b0;
            receiving <= 1'b0;
        end else begin
            state     <= state_nx;
            RXD       <= rxd_nx;
            RX_DV     <= dv_nx;
            RX_ER     <= er_nx;
            receiving <= recv_nx;
        end
    end

endmodule

// File: tb/tb_pcs_receive.sv
// Bench for pcs_receive: directed vector table, then random code-group
// traffic checked against an encoder-derived reference model.
module tb_pcs_receive;

    logic        Clk = 1'b0;
    logic        mr_main_reset;
    logic        code_sync_status;
    logic [10:0] SUDI;
    logic [7:0]  RXD;
    logic        RX_DV;
    logic        RX_ER;
    logic        receiving;

    always #5 Clk = ~Clk;

    pcs_receive dut (
        .Clk              (Clk),
        .mr_main_reset    (mr_main_reset),
        .code_sync_status (code_sync_status),
        .SUDI             (SUDI),
        .RXD              (RXD),
        .RX_DV            (RX_DV),
        .RX_ER            (RX_ER),
        .receiving        (receiving)
    );

    localparam logic [9:0] K285 = 10'b0011111010;
    localparam logic [9:0] K281 = 10'b0011111001;
    localparam logic [9:0] SS   = 10'b1101101000;
    localparam logic [9:0] TT   = 10'b1011101000;
    localparam logic [9:0] RR   = 10'b1110101000;
    localparam logic [9:0] D215 = 10'b1010101010;
    localparam logic [9:0] D00  = 10'b1001110100;
    localparam logic [9:0] D162 = 10'b1001000101;
    localparam logic [9:0] BAD  = 10'b0000000000;

    typedef struct {
        bit         rst;
        bit         sync;
        bit         even;
        logic [9:0] cg;
        logic [7:0] rxd;
        bit         dv;
        bit         er;
        bit         rcv;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // RD- encoding tables used to generate every legal data group
    bit [5:0] t6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001,
        6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100,
        6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010,
        6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110,
        6'b001110, 6'b101110, 6'b011110, 6'b101011
    };
    bit [3:0] t4 [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100,
        4'b1101, 4'b1010, 4'b0110, 4'b1110
    };

    logic [7:0] dmap [logic [9:0]];
    logic [9:0] dlist[$];

    function automatic logic [9:0] enc(input int b, input bit pos);
        logic [5:0] s;
        logic [3:0] f;
        int         x;
        int         y;
        bit         mid;
        x = b % 32;
        y = b / 32;
        s = t6[x];
        if (pos && ($countones(s) != 3 || x == 7))
            s = ~s;
        mid = ($countones(s) != 3) ? !pos : pos;
        if (y == 7) begin
            if ((!mid && (x == 17 || x == 18 || x == 20)) ||
                (mid && (x == 11 || x == 13 || x == 14)))
                f = mid ? 4'b1000 : 4'b0111;
            else
                f = mid ? 4'b0001 : 4'b1110;
        end else begin
            f = t4[y];
            if (mid && ($countones(f) != 2 || y == 3))
                f = ~f;
        end
        return {s, f};
    endfunction

    // reference model state
    localparam int M_LF  = 0;
    localparam int M_WK  = 1;
    localparam int M_RK  = 2;
    localparam int M_ID  = 3;
    localparam int M_CE  = 4;
    localparam int M_PKT = 5;
    localparam int M_EOP = 6;
    localparam int M_EXT = 7;

    int         m_st   = M_LF;
    bit         m_recv = 1'b0;
    logic [7:0] e_rxd;
    bit         e_dv;
    bit         e_er;

    task automatic ref_step(input bit rst, input bit sync, input bit even,
                            input logic [9:0] cg);
        bit k285;
        bit sop;
        bit term;
        bit rr;
        bit isd;
        k285  = (cg == K285) || (cg == ~K285);
        sop   = (cg == SS) || (cg == ~SS);
        term  = (cg == TT) || (cg == ~TT);
        rr    = (cg == RR) || (cg == ~RR);
        isd   = dmap.exists(cg);
        e_rxd = 8'h00;
        e_dv  = 1'b0;
        e_er  = 1'b0;
        if (!rst) begin
            m_st   = M_LF;
            m_recv = 1'b0;
        end else if (!sync) begin
            e_er   = m_recv;
            m_recv = 1'b0;
            m_st   = M_LF;
        end else begin
            case (m_st)
                M_LF: m_st = M_WK;
                M_WK: if (k285 && even) m_st = M_RK;
                M_RK: m_st = isd ? M_ID : M_WK;
                M_ID: begin
                    if (k285) m_st = M_RK;
                    else if (sop) begin
                        m_st = M_PKT; m_recv = 1'b1;
                        e_dv = 1'b1; e_rxd = 8'h55;
                    end else begin
                        m_st = M_CE; e_er = 1'b1; e_rxd = 8'h0E;
                    end
                end
                M_CE: m_st = k285 ? M_RK : M_WK;
                M_PKT: begin
                    if (isd) begin
                        e_dv = 1'b1; e_rxd = dmap[cg];
                    end else if (term) begin
                        m_st = M_EOP;
                    end else if (k285 && even) begin
                        m_st = M_RK; m_recv = 1'b0; e_er = 1'b1;
                    end else begin
                        e_dv = 1'b1; e_er = 1'b1;
                    end
                end
                M_EOP: begin
                    m_recv = 1'b0;
                    if (rr) m_st = M_EXT;
                    else begin
                        m_st = M_WK; e_er = 1'b1;
                    end
                end
                M_EXT: if (!rr) m_st = k285 ? M_RK : M_WK;
                default: m_st = M_LF;
            endcase
        end
    endtask

    task automatic add(input bit rst, input bit sync, input bit even,
                       input logic [9:0] cg, input logic [7:0] rxd,
                       input bit dv, input bit er, input bit rcv);
        vec_t v;
        v.rst = rst; v.sync = sync; v.even = even; v.cg = cg;
        v.rxd = rxd; v.dv = dv; v.er = er; v.rcv = rcv;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit rst, input bit sync, input bit even,
                         input logic [9:0] cg);
        @(negedge Clk);
        mr_main_reset    = rst;
        code_sync_status = sync;
        SUDI             = {even, cg};
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] rxd,
                         input bit dv, input bit er, input bit rcv);
        n_tests++;
        if ({RXD, RX_DV, RX_ER, receiving} !== {rxd, dv, er, rcv}) begin
            n_fail++;
            $display("FAIL %s: got rxd=%h dv=%b er=%b rcv=%b want rxd=%h dv=%b er=%b rcv=%b",
                     name, RXD, RX_DV, RX_ER, receiving, rxd, dv, er, rcv);
        end
    endtask

    initial begin
        mr_main_reset    = 1'b0;
        code_sync_status = 1'b0;
        SUDI             = 11'd0;

        for (int rd = 0; rd < 2; rd++)
            for (int b = 0; b < 256; b++) begin
                logic [9:0] c;
                c = enc(b, rd[0]);
                dmap[c] = b[7:0];
                dlist.push_back(c);
            end

        // reset, then reach IDLE_D
        add(0, 1, 1, K285, 8'h00, 0, 0, 0);
        add(0, 1, 0, D215, 8'h00, 0, 0, 0);
        add(1, 1, 1, K285, 8'h00, 0, 0, 0);
        add(1, 1, 0, D215, 8'h00, 0, 0, 0);
        add(1, 1, 1, K285, 8'h00, 0, 0, 0);
        add(1, 1, 0, D215, 8'h00, 0, 0, 0);
        add(1, 1, 1, K285, 8'h00, 0, 0, 0);
        add(1, 1, 0, D215, 8'h00, 0, 0, 0);
        // clean packet with extend
        add(1, 1, 1, SS,   8'h55, 1, 0, 1);
        add(1, 1, 0, D00,  8'h00, 1, 0, 1);
        add(1, 1, 1, D162, 8'h50, 1, 0, 1);
        add(1, 1, 0, TT,   8'h00, 0, 0, 1);
        add(1, 1, 1, RR,   8'h00, 0, 0, 0);
        add(1, 1, 0, RR,   8'h00, 0, 0, 0);
        add(1, 1, 1, K285, 8'h00, 0, 0, 0);
        add(1, 1, 0, D215, 8'h00, 0, 0, 0);
        // data error then recovery
        add(1, 1, 1, SS,   8'h55, 1, 0, 1);
        add(1, 1, 0, BAD,  8'h00, 1, 1, 1);
        add(1, 1, 1, D00,  8'h00, 1, 0, 1);
        // early end
        add(1, 1, 0, D00,  8'h00, 1, 0, 1);
        add(1, 1, 1, K285, 8'h00, 0, 1, 0);
        add(1, 1, 0, D215, 8'h00, 0, 0, 0);
        // sync loss mid-packet
        add(1, 1, 1, SS,   8'h55, 1, 0, 1);
        add(1, 1, 0, D162, 8'h50, 1, 0, 1);
        add(1, 0, 1, D00,  8'h00, 0, 1, 0);
        add(1, 0, 0, D00,  8'h00, 0, 0, 0);
        add(1, 1, 1, K285, 8'h00, 0, 0, 0);
        add(1, 1, 0, D215, 8'h00, 0, 0, 0);
        add(1, 1, 1, K285, 8'h00, 0, 0, 0);
        add(1, 1, 0, D215, 8'h00, 0, 0, 0);
        // false carrier, single cycle
        add(1, 1, 1, D00,  8'h0E, 0, 1, 0);
        add(1, 1, 0, D215, 8'h00, 0, 0, 0);
        // EOP without /R/
        add(1, 1, 1, K285, 8'h00, 0, 0, 0);
        add(1, 1, 0, D215, 8'h00, 0, 0, 0);
        add(1, 1, 1, SS,   8'h55, 1, 0, 1);
        add(1, 1, 0, TT,   8'h00, 0, 0, 1);
        add(1, 1, 1, D00,  8'h00, 0, 1, 0);
        add(1, 1, 0, D215, 8'h00, 0, 0, 0);
        // reset mid-packet
        add(1, 1, 1, K285, 8'h00, 0, 0, 0);
        add(1, 1, 0, D215, 8'h00, 0, 0, 0);
        add(1, 1, 1, SS,   8'h55, 1, 0, 1);
        add(1, 1, 0, D00,  8'h00, 1, 0, 1);
        add(0, 1, 1, D00,  8'h00, 0, 0, 0);
        add(0, 1, 0, D00,  8'h00, 0, 0, 0);
        add(1, 1, 1, K285, 8'h00, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].sync, vecs[i].even, vecs[i].cg);
            check($sformatf("vec%0d", i), vecs[i].rxd, vecs[i].dv,
                  vecs[i].er, vecs[i].rcv);
        end

        // random traffic against the reference model
        begin
            bit ev;
            ev = 1'b1;
            drive(0, 1, ev, K285);
            ref_step(0, 1, ev, K285);
            for (int n = 0; n < 3000; n++) begin
                bit         rst;
                bit         sync;
                int         p;
                logic [9:0] cg;
                ev   = !ev;
                rst  = ($urandom_range(0, 199) != 0);
                sync = ($urandom_range(0, 99) >= 2);
                p    = $urandom_range(0, 99);
                if (p < 25)      cg = K285;
                else if (p < 35) cg = SS;
                else if (p < 73) cg = dlist[$urandom_range(0, dlist.size() - 1)];
                else if (p < 81) cg = TT;
                else if (p < 89) cg = RR;
                else if (p < 93) cg = K281;
                else if (p < 97) cg = BAD;
                else             cg = 10'h3FF;
                if (!dmap.exists(cg) && $urandom_range(0, 1) == 1)
                    cg = ~cg;
                drive(rst, sync, ev, cg);
                ref_step(rst, sync, ev, cg);
                check($sformatf("rand%0d cg=%b", n, cg), e_rxd, e_dv,
                      e_er, m_recv);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
